// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite pixel pipeline.
package sprite_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

  localparam int H_MAX = 640;
  localparam int V_MAX = 480;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic in,
  output logic rise
);

  logic prev;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/sprite_fetch.sv
// Sprite fetch: per-pixel box hit test and sprite-ROM address generation with
// walk animation, frame-latched position and a two-cycle output pipeline.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W    = 24,
  parameter int SPR_H    = 32,
  parameter int N_FRAMES = 4,
  parameter int ANIM_DIV = 6,
  parameter int ADDR_W   = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              facing_left,
  input  logic              moving,
  input  logic              visible,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              is_sprite,
  output logic [7:0]        sprite_data
);

  localparam int FRAME_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FRAME_SIZE = SPR_W * SPR_H;

  logic tick;

  edge_detect u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .in    (frame_clk),
    .rise  (tick)
  );

  // Shadow copies: position/orientation only change at a frame boundary.
  logic [9:0] sprite_x_s, sprite_y_s;
  logic       facing_left_s, visible_s;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprite_x_s    <= '0;
      sprite_y_s    <= '0;
      facing_left_s <= 1'b0;
      visible_s     <= 1'b0;
    end else if (tick) begin
      sprite_x_s    <= sprite_x;
      sprite_y_s    <= sprite_y;
      facing_left_s <= facing_left;
      visible_s     <= visible;
    end
  end

  anim_state_t        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      div_q   <= div_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    div_d   = div_q;
    if (tick) begin
      if (!moving) begin
        state_d = IDLE;
        frame_d = '0;
        div_d   = '0;
      end else if (state_q == IDLE) begin
        state_d = WALK;
        frame_d = '0;
        div_d   = '0;
      end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FRAME_W'(N_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        div_d   = div_q + DIV_W'(1);
      end
    end
  end

  // Stage 0: 11-bit box bounds so a sprite near the right/bottom edge never wraps to 0.
  logic [10:0]       x_end, y_end;
  logic              hit_x, hit_y, hit;
  logic [9:0]        col_raw, col, row;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    x_end     = {1'b0, sprite_x_s} + 11'(SPR_W);
    y_end     = {1'b0, sprite_y_s} + 11'(SPR_H);
    hit_x     = (DrawX >= sprite_x_s) && ({1'b0, DrawX} < x_end);
    hit_y     = (DrawY >= sprite_y_s) && ({1'b0, DrawY} < y_end);
    hit       = visible_s && hit_x && hit_y;
    col_raw   = DrawX - sprite_x_s;
    col       = facing_left_s ? 10'(SPR_W - 1) - col_raw : col_raw;
    row       = DrawY - sprite_y_s;
    addr_next = hit ? ADDR_W'(FRAME_SIZE * int'(frame_q) + SPR_W * int'(row) + int'(col))
                    : '0;
  end

  logic hit_d1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      hit_d1    <= 1'b0;
      is_sprite <= 1'b0;
    end else begin
      rom_addr  <= addr_next;
      hit_d1    <= hit;
      is_sprite <= hit_d1;
    end
  end

  // rom_data is already the ROM's registered output, aligned with is_sprite; gating it
  // here keeps the end-to-end latency at two cycles and forces 0 outside the box.
  assign sprite_data = is_sprite ? rom_data : 8'h00;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: a frame-level reference model predicts each
// pixel's address and output; a monitor compares them as the pipeline delivers them.
module tb_sprite_fetch;

  localparam int SPR_W    = 24;
  localparam int SPR_H    = 32;
  localparam int N_FRAMES = 4;
  localparam int ANIM_DIV = 6;
  localparam int ADDR_W   = 12;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              frame_clk;
  logic [9:0]        DrawX, DrawY, sprite_x, sprite_y;
  logic              facing_left, moving, visible;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              is_sprite;
  logic [7:0]        sprite_data;

  sprite_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES), .ANIM_DIV(ANIM_DIV), .ADDR_W(ADDR_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .facing_left (facing_left),
    .moving      (moving),
    .visible     (visible),
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .is_sprite   (is_sprite),
    .sprite_data (sprite_data)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read sprite ROM with random contents (zeros included).
  logic [7:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    int due;
    bit hit;
    int addr;
  } exp_t;

  exp_t addr_q[$];
  exp_t data_q[$];
  bit   rst_edge[int];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Reference model: frame-level state, updated only by ticks and reset.
  int sx_s, sy_s, walk_ticks;
  bit fl_s, vis_s, walking, prev_fc;

  function automatic int model_frame();
    return walking ? ((walk_ticks - 1) / ANIM_DIV) % N_FRAMES : 0;
  endfunction

  function automatic void model_pix(input int dx, input int dy, output bit h, output int a);
    int col, row;
    h   = vis_s && dx >= sx_s && dx < sx_s + SPR_W && dy >= sy_s && dy < sy_s + SPR_H;
    col = dx - sx_s;
    if (fl_s) col = SPR_W - 1 - col;
    row = dy - sy_s;
    a   = h ? (model_frame() * SPR_W * SPR_H + row * SPR_W + col) % (1 << ADDR_W) : 0;
  endfunction

  // One pixel clock: drive, predict, enqueue, then advance the model past the edge.
  task automatic step(input bit fc, input bit rst, input int dx, input int dy);
    exp_t e;
    bit   h;
    int   a;
    frame_clk = fc;
    Reset     = rst;
    DrawX     = 10'(dx);
    DrawY     = 10'(dy);
    model_pix(dx & 1023, dy & 1023, h, a);
    e.due  = cyc + 1;
    e.hit  = h;
    e.addr = a;
    addr_q.push_back(e);
    if (rst) rst_edge[cyc + 1] = 1'b1;
    if (rst) begin
      sx_s = 0; sy_s = 0; fl_s = 0; vis_s = 0;
      walking = 0; walk_ticks = 0; prev_fc = 0;
    end else begin
      if (fc && !prev_fc) begin
        sx_s  = int'(sprite_x);
        sy_s  = int'(sprite_y);
        fl_s  = facing_left;
        vis_s = visible;
        if (!moving) begin
          walking = 0; walk_ticks = 0;
        end else if (!walking) begin
          walking = 1; walk_ticks = 1;
        end else begin
          walk_ticks++;
        end
      end
      prev_fc = fc;
    end
    @(posedge Clk);
    #1;
  endtask

  function automatic int near_x();
    return (sx_s - 3 + int'($urandom_range(0, SPR_W + 5))) & 1023;
  endfunction

  function automatic int near_y();
    return (sy_s - 3 + int'($urandom_range(0, SPR_H + 5))) & 1023;
  endfunction

  // Monitor: compares whatever the pipeline presents against queued predictions.
  always @(negedge Clk) begin
    exp_t e;
    bit   live;
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      e = addr_q.pop_front();
      check("addr_due", e.due, cyc);
      if (rst_edge.exists(e.due)) begin
        e.hit  = 1'b0;
        e.addr = 0;
      end
      check("rom_addr", int'(rom_addr), e.addr);
      e.due = e.due + 1;
      data_q.push_back(e);
    end
    while (data_q.size() > 0 && data_q[0].due <= cyc) begin
      e = data_q.pop_front();
      check("data_due", e.due, cyc);
      live = e.hit && !rst_edge.exists(e.due);
      check("is_sprite", int'(is_sprite), int'(live));
      check("sprite_data", int'(sprite_data), live ? int'(rom[e.addr]) : 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    Reset = 1'b1; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
    sprite_x = '0; sprite_y = '0; facing_left = 1'b0; moving = 1'b0; visible = 1'b0;
    sx_s = 0; sy_s = 0; fl_s = 0; vis_s = 0; walking = 0; walk_ticks = 0; prev_fc = 0;
    repeat (2) @(posedge Clk);
    #1;
    step(0, 1, 0, 0);
    step(0, 1, 100, 200);

    // Basic fetch, facing right then mirrored, box edges.
    sprite_x = 10'd100; sprite_y = 10'd200; visible = 1'b1;
    step(0, 0, 100, 200);
    step(1, 0, 100, 200);
    step(0, 0, 100, 200);
    step(0, 0, 100, 201);
    step(0, 0, 123, 231);
    step(0, 0, 124, 200);
    step(0, 0, 99, 200);
    step(0, 0, 100, 232);
    facing_left = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 100, 201);
    step(0, 0, 123, 200);

    // Walk animation, including a one-tick stop in the middle.
    facing_left = 1'b0;
    for (int t = 0; t < 30; t++) begin
      moving = (t == 13) ? 1'b0 : 1'b1;
      step(1, 0, near_x(), near_y());
      for (int p = 0; p < 4; p++) step(0, 0, near_x(), near_y());
    end

    // Right-edge sprite must not wrap onto small X; position change waits for a tick.
    moving = 1'b0; sprite_x = 10'd630; sprite_y = 10'd100;
    step(1, 0, 5, 110);
    step(0, 0, 5, 110);
    step(0, 0, 0, 110);
    step(0, 0, 639, 110);
    step(0, 0, 630, 131);
    step(0, 0, 653, 110);
    step(0, 0, 654, 110);
    sprite_x = 10'd200;
    step(0, 0, 205, 110);
    step(0, 0, 635, 110);
    step(1, 0, 205, 110);
    step(0, 0, 205, 110);
    step(0, 0, 635, 110);

    // One-cycle reset while inside the box; outputs stay 0 until the next tick.
    step(0, 0, 210, 115);
    step(0, 1, 210, 116);
    for (int p = 0; p < 4; p++) step(0, 0, 210, 117);
    step(1, 0, 210, 118);
    step(0, 0, 210, 119);
    step(0, 0, 210, 120);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        sprite_x    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 1023))
                                                  : 10'($urandom_range(0, 620));
        sprite_y    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(450, 1023))
                                                  : 10'($urandom_range(0, 450));
        facing_left = 1'($urandom_range(0, 1));
        visible     = ($urandom_range(0, 5) != 0);
      end
      if ($urandom_range(0, 31) == 0) moving = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        step(1'($urandom_range(0, 3) == 0), $urandom_range(0, 199) == 0,
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      else
        step(1'($urandom_range(0, 3) == 0), $urandom_range(0, 199) == 0, near_x(), near_y());
    end

    step(0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #1;
    check("drain", addr_q.size() + data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
